// File: rtl/knn_pkg.sv
// Shared KNN datapath definitions: distance-unit state encoding and sizing helpers.
package knn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ACCUM     = 2'd1,
        ST_CHUNK_END = 2'd2
    } acc_state_t;

    function automatic int unsigned clog2_fn(input int unsigned value);
        int unsigned result;
        result = 0;
        for (longint unsigned p = 1; p < longint'(value); p = p << 1) begin
            result = result + 1;
        end
        return result;
    endfunction

    function automatic int unsigned min_fn(input int unsigned a, input int unsigned b);
        return (a < b) ? a : b;
    endfunction

    function automatic int unsigned max_fn(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    function automatic int unsigned total_size(input int unsigned m, input int unsigned n);
        return m * n;
    endfunction

    function automatic int unsigned chunk_size(input int unsigned max_elements,
                                               input int unsigned m, input int unsigned n);
        return min_fn(max_elements, m * n);
    endfunction

    // Sum of M*N squared W-bit differences needs 2W plus log2(M*N) bits.
    function automatic int unsigned dist_width(input int unsigned w,
                                               input int unsigned m, input int unsigned n);
        return 2 * w + clog2_fn(m * n);
    endfunction

endpackage

// File: rtl/sq_diff_unit.sv
// Combinational squared difference of two unsigned operands.
module sq_diff_unit #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] sq_c
);

    localparam int unsigned W2 = 2 * W;

    logic [W-1:0] diff;

    always_comb begin
        diff = (a >= b) ? (a - b) : (b - a);
        sq_c = W2'(diff) * W2'(diff);
    end

endmodule

// File: rtl/distance_accumulator.sv
// Accumulates squared Euclidean distance over chunked input/training vectors,
// one element per cycle, and reports the per-vector result with its label.
module distance_accumulator
    import knn_pkg::*;
#(
    parameter int unsigned M            = 4,
    parameter int unsigned N            = 4,
    parameter int unsigned W            = 8,
    parameter int unsigned MAX_ELEMENTS = 8,
    parameter int unsigned TYPE_W       = 4,
    parameter int unsigned L            = 16,
    parameter int unsigned DIST_W       = dist_width(W, M, N),
    localparam int unsigned IDX_W       = max_fn(1, clog2_fn(L))
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      read_done,
    input  logic [W*MAX_ELEMENTS-1:0] input_data,
    input  logic [W*MAX_ELEMENTS-1:0] training_data,
    input  logic [TYPE_W-1:0]         training_data_type,
    output logic                      data_request,
    output logic                      done,
    output logic [DIST_W-1:0]         distance,
    output logic [TYPE_W-1:0]         distance_type,
    output logic [IDX_W-1:0]          vector_index,
    output logic                      busy,
    output logic                      overrun
);

    localparam int unsigned CHUNK  = chunk_size(MAX_ELEMENTS, M, N);
    localparam int unsigned TOTAL  = total_size(M, N);
    localparam int unsigned ELEM_W = max_fn(1, clog2_fn(MAX_ELEMENTS));
    localparam int unsigned CNT_W  = max_fn(1, clog2_fn(TOTAL + 1));
    localparam int unsigned N_W    = max_fn(1, clog2_fn(CHUNK + 1));

    acc_state_t                       state;
    logic [MAX_ELEMENTS-1:0][W-1:0]   in_q;
    logic [MAX_ELEMENTS-1:0][W-1:0]   tr_q;
    logic [TYPE_W-1:0]                type_q;
    logic [ELEM_W-1:0]                e_q;
    logic [N_W-1:0]                   n_q;
    logic [CNT_W-1:0]                 consumed_q;
    logic [DIST_W-1:0]                acc_q;
    logic [2*W-1:0]                   term_c;
    logic [CNT_W-1:0]                 remaining_c;
    logic [N_W-1:0]                   n_next_c;

    sq_diff_unit #(.W(W)) u_sq_diff (
        .a    (in_q[e_q]),
        .b    (tr_q[e_q]),
        .sq_c (term_c)
    );

    // Elements to process in the incoming chunk: whatever of the vector is left, capped at CHUNK.
    always_comb begin
        remaining_c = CNT_W'(TOTAL) - consumed_q;
        n_next_c    = (remaining_c > CNT_W'(CHUNK)) ? N_W'(CHUNK) : N_W'(remaining_c);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            in_q          <= '0;
            tr_q          <= '0;
            type_q        <= '0;
            e_q           <= '0;
            n_q           <= '0;
            consumed_q    <= '0;
            acc_q         <= '0;
            data_request  <= 1'b0;
            done          <= 1'b0;
            distance      <= '0;
            distance_type <= '0;
            vector_index  <= '0;
            busy          <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            data_request <= 1'b0;
            done         <= 1'b0;

            // Index shows the completed vector during done, then moves on.
            if (done) begin
                vector_index <= (vector_index == IDX_W'(L - 1)) ? '0 : vector_index + IDX_W'(1);
            end

            if (read_done && state != ST_IDLE) begin
                overrun <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (read_done) begin
                        in_q  <= input_data;
                        tr_q  <= training_data;
                        if (consumed_q == '0) begin
                            type_q <= training_data_type;
                        end
                        n_q   <= n_next_c;
                        e_q   <= '0;
                        busy  <= 1'b1;
                        state <= ST_ACCUM;
                    end
                end

                ST_ACCUM: begin
                    acc_q      <= acc_q + DIST_W'(term_c);
                    consumed_q <= consumed_q + CNT_W'(1);
                    if (N_W'(e_q) == n_q - N_W'(1)) begin
                        state <= ST_CHUNK_END;
                    end else begin
                        e_q <= e_q + ELEM_W'(1);
                    end
                end

                ST_CHUNK_END: begin
                    if (consumed_q == CNT_W'(TOTAL)) begin
                        done          <= 1'b1;
                        distance      <= acc_q;
                        distance_type <= type_q;
                        acc_q         <= '0;
                        consumed_q    <= '0;
                    end else begin
                        data_request <= 1'b1;
                    end
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/distance_accumulator.md
Name: distance_accumulator

Overview:
- Consumer end of the memory-control data handshake in the KNN datapath.
- Memory control delivers packed chunks of input and training elements with a read_done pulse. This block computes the squared Euclidean distance one element per cycle and accumulates it across chunks.
- After each chunk it pulses data_request if more elements of the current vector remain. After the last chunk it pulses done with the final distance and the training type.
- Its outputs feed the k-nearest sorter / voter downstream.

Parameters:
- M, 4, image rows per vector.
- N, 4, image columns per vector.
- W, 8, element width in bits (unsigned).
- MAX_ELEMENTS, 8, maximum elements per delivered chunk.
- TYPE_W, 4, training class-label width.
- L, 16, training vectors per inference (used only for vector_index wrap).
- DIST_W, 2*W+$clog2(M*N), accumulator/distance width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- read_done  in  1  one-cycle pulse: chunk buses valid this cycle.
- input_data  in  W*MAX_ELEMENTS  packed input chunk; element j at [W*(j+1)-1 -: W].
- training_data  in  W*MAX_ELEMENTS  packed training chunk, same packing as input_data.
- training_data_type  in  TYPE_W  label of the current training vector.
- data_request  out  1  one-cycle pulse: next chunk of the same vector needed.
- done  out  1  one-cycle pulse: vector distance complete.
- distance  out  DIST_W  final squared distance; valid with done, held until the next done.
- distance_type  out  TYPE_W  label captured with the vector; held with distance.
- vector_index  out  $clog2(L)  index of the vector just completed; wraps L-1 -> 0.
- busy  out  1  high in every state except IDLE.
- overrun  out  1  sticky: read_done arrived while busy; cleared only by rst.

Behaviour:
- Constants: CHUNK = min(MAX_ELEMENTS, M*N); TOTAL = M*N.
- Reset (synchronous, rst high at posedge): all outputs 0, accumulator 0, consumed count 0, vector_index 0, state IDLE. Reset mid-operation aborts the vector with no done and no data_request pulse.
- IDLE: on read_done, register both chunk buses and training_data_type. Set n = min(CHUNK, TOTAL - consumed) and e = 0. Next state ACCUM.
- ACCUM: per cycle, d = |in[e] - tr[e]| (W bits, unsigned). Add d*d (2W bits) to the accumulator (DIST_W bits, no saturation needed). Then e++ and consumed++. When e == n-1, go to CHUNK_END.
- CHUNK_END, if consumed < TOTAL: pulse data_request for 1 cycle, return to IDLE, keep the accumulator.
- CHUNK_END, if consumed == TOTAL:
  - Pulse done for 1 cycle; distance <= accumulator including the last term; distance_type <= captured type.
  - vector_index advances after the pulse (the output shows the completed vector's index during done).
  - Clear the accumulator and consumed; return to IDLE.
- Latency: read_done at cycle t gives the first term at t+1, the last term at t+n, and the done/data_request pulse at t+n+1.
- Type label is captured only on the first chunk of a vector (consumed == 0). Later chunks ignore training_data_type.
- read_done while busy: the chunk is ignored, overrun is set, and the current computation is unaffected.
- read_done coincident with rst: rst wins.
- done and data_request are never high in the same cycle.
- Elements above index n-1 in a chunk are ignored.

Decomposition:
- Shared package knn_pkg: state encoding, CHUNK/TOTAL localparam functions, a clog2 helper, and DIST_W derivation (shared with the sorter).
- One sub-module, sq_diff_unit: combinational |a-b|^2 on W-bit unsigned operands giving a 2W-bit result. The FSM and accumulator stay in the top level.

Test Plan:
- M=N=2, MAX_ELEMENTS=4: input {1,2,3,4}, training {4,2,0,4}, type 3. Expect done at t+5, distance=18, distance_type=3, vector_index=0, no data_request.
- M=N=2, MAX_ELEMENTS=3, same vectors:
  - data_request pulse at t+4.
  - A second read_done with element 0 = in 4 / tr 4 gives done 2 cycles later, distance=18.
  - The type from the second chunk is ignored.
- Extremes, M=N=2, W=8: all-255 input vs all-0 training gives distance=260100 with no overflow in DIST_W=18.
- Three consecutive vectors with L=3: vector_index reads 0,1,2 at each done, then 0 on the fourth. The accumulator restarts at 0 each vector.
- read_done asserted during ACCUM: overrun=1, final distance unchanged from the undisturbed case.
- rst mid-ACCUM, then a fresh vector: no done from the aborted vector, correct distance for the new one, overrun=0.
